// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels as BGR888 into 32-bit AXI-Stream words (4 pixels -> 3 words).
// Optional statistics counters are enabled with `define PACKER_STATS_EN.
`timescale 1ns/1ps

module rgb_stream_packer #(
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_PER_PIX = 3
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [7:0]                r,
   input  logic [7:0]                g,
   input  logic [7:0]                b,
   input  logic                      valid,
   input  logic                      sof,
   input  logic                      eol,
   output logic                      in_stream_ready,
   output logic [DATA_WIDTH-1:0]     out_stream_tdata,
   output logic [DATA_WIDTH/8-1:0]   out_stream_tkeep,
   output logic                      out_stream_tlast,
   output logic                      out_stream_tuser,
   output logic                      out_stream_tvalid,
   input  logic                      out_stream_tready
`ifdef PACKER_STATS_EN
   ,
   output logic [15:0]               frame_count,
   output logic [15:0]               misalign_count
`endif
);

   localparam int PIX_W  = 8 * BYTE_PER_PIX;
   localparam int KEEP_W = DATA_WIDTH / 8;

   // Pixel as a byte vector: byte 0 = b, byte 1 = g, byte 2 = r.
   logic [PIX_W-1:0]      pix;
   logic                  out_free;
   logic                  ready;
   logic                  accept;
   logic                  misalign;
   logic [1:0]            eff_phase;
   logic                  sof_now;

   logic [1:0]            phase_q, phase_d;
   logic [PIX_W-1:0]      left_q, left_d;
   logic                  sof_pending_q, sof_pending_d;
   logic                  flush_pending_q, flush_pending_d;
   logic [DATA_WIDTH-1:0] flush_data_q, flush_data_d;
   logic [KEEP_W-1:0]     flush_keep_q, flush_keep_d;

   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
   logic                  tlast_q, tlast_d;
   logic                  tuser_q, tuser_d;
   logic                  tvalid_q, tvalid_d;

   logic                  emit;
   logic [DATA_WIDTH-1:0] word_data;
   logic [KEEP_W-1:0]     word_keep;
   logic                  word_last;
   logic                  word_user;

   always_comb begin
      pix       = {r, g, b};
      out_free  = !tvalid_q || out_stream_tready;
      ready     = out_free && !flush_pending_q && !areset;
      accept    = valid && ready;
      misalign  = accept && sof && (phase_q != 2'd0);
      // A misplaced start-of-frame abandons the held bytes and restarts the group.
      eff_phase = misalign ? 2'd0 : phase_q;
      sof_now   = sof_pending_q || (accept && sof);
   end

   always_comb begin
      phase_d         = phase_q;
      left_d          = left_q;
      sof_pending_d   = sof_pending_q;
      flush_pending_d = flush_pending_q;
      flush_data_d    = flush_data_q;
      flush_keep_d    = flush_keep_q;
      emit            = 1'b0;
      word_data       = '0;
      word_keep       = '0;
      word_last       = 1'b0;
      word_user       = 1'b0;

      if (accept) begin
         left_d        = pix;
         phase_d       = eol ? 2'd0 : eff_phase + 2'd1;
         sof_pending_d = sof_now;
         case (eff_phase)
            2'd0: begin
               if (eol) begin
                  emit      = 1'b1;
                  word_data = {8'h00, pix};
                  word_keep = 4'b0111;
                  word_last = 1'b1;
               end
            end
            2'd1: begin
               emit      = 1'b1;
               word_data = {pix[7:0], left_q};
               word_keep = 4'b1111;
               if (eol) begin
                  flush_pending_d = 1'b1;
                  flush_data_d    = {16'h0000, pix[23:8]};
                  flush_keep_d    = 4'b0011;
               end
            end
            2'd2: begin
               emit      = 1'b1;
               word_data = {pix[15:0], left_q[23:8]};
               word_keep = 4'b1111;
               if (eol) begin
                  flush_pending_d = 1'b1;
                  flush_data_d    = {24'h000000, pix[23:16]};
                  flush_keep_d    = 4'b0001;
               end
            end
            default: begin
               emit      = 1'b1;
               word_data = {pix, left_q[23:16]};
               word_keep = 4'b1111;
               word_last = eol;
            end
         endcase
         if (emit) begin
            word_user     = sof_now;
            sof_pending_d = 1'b0;
         end
      end
   end

   // Output register: an accept only happens when the slot is free, and no
   // accept can coincide with a pending flush, so the two loads never collide.
   always_comb begin
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      tvalid_d = tvalid_q;
      if (out_free) begin
         if (emit) begin
            tvalid_d = 1'b1;
            tdata_d  = word_data;
            tkeep_d  = word_keep;
            tlast_d  = word_last;
            tuser_d  = word_user;
         end else if (flush_pending_q) begin
            tvalid_d = 1'b1;
            tdata_d  = flush_data_q;
            tkeep_d  = flush_keep_q;
            tlast_d  = 1'b1;
            tuser_d  = 1'b0;
         end else begin
            tvalid_d = 1'b0;
         end
      end
   end

   // The flush clear lives here because only the output side knows when the
   // flush word has actually been loaded.
   logic flush_pending_nx;
   always_comb begin
      flush_pending_nx = flush_pending_d;
      if (out_free && !emit && flush_pending_q) begin
         flush_pending_nx = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         phase_q         <= 2'd0;
         left_q          <= '0;
         sof_pending_q   <= 1'b0;
         flush_pending_q <= 1'b0;
         flush_data_q    <= '0;
         flush_keep_q    <= '0;
         tdata_q         <= '0;
         tkeep_q         <= '0;
         tlast_q         <= 1'b0;
         tuser_q         <= 1'b0;
         tvalid_q        <= 1'b0;
      end else begin
         phase_q         <= phase_d;
         left_q          <= left_d;
         sof_pending_q   <= sof_pending_d;
         flush_pending_q <= flush_pending_nx;
         flush_data_q    <= flush_data_d;
         flush_keep_q    <= flush_keep_d;
         tdata_q         <= tdata_d;
         tkeep_q         <= tkeep_d;
         tlast_q         <= tlast_d;
         tuser_q         <= tuser_d;
         tvalid_q        <= tvalid_d;
      end
   end

   assign in_stream_ready   = ready;
   assign out_stream_tdata  = tdata_q;
   assign out_stream_tkeep  = tkeep_q;
   assign out_stream_tlast  = tlast_q;
   assign out_stream_tuser  = tuser_q;
   assign out_stream_tvalid = tvalid_q;

`ifdef PACKER_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [15:0] misalign_cnt_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         frame_cnt_q    <= 16'h0000;
         misalign_cnt_q <= 16'h0000;
      end else begin
         if (tvalid_q && out_stream_tready && tuser_q && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         if (misalign && (misalign_cnt_q != 16'hFFFF)) begin
            misalign_cnt_q <= misalign_cnt_q + 16'd1;
         end
      end
   end

   assign frame_count    = frame_cnt_q;
   assign misalign_count = misalign_cnt_q;
`endif

endmodule

// File: doc/rgb_stream_packer.md
Name: rgb_stream_packer

Overview:
- Sits directly downstream of the pixel generator.
- Accepts one 24-bit RGB pixel per handshake, with start-of-frame and end-of-line flags.
- Packs pixels densely as BGR888 into 32-bit AXI-Stream words for the VDMA: 4 pixels become 3 words.
- Handles backpressure, flushes partial words at line end, and realigns on a misplaced start-of-frame.

Parameters:
- DATA_WIDTH, 32, output word width in bits; fixed at 32, other values unsupported.
- BYTE_PER_PIX, 3, bytes per pixel; fixed at 3.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  synchronous, active-high reset.
- r  in  8  pixel red.
- g  in  8  pixel green.
- b  in  8  pixel blue.
- valid  in  1  input pixel valid.
- sof  in  1  pixel is first of frame; qualified by valid.
- eol  in  1  pixel is last of line; qualified by valid.
- in_stream_ready  out  1  packer can accept a pixel this cycle.
- out_stream_tdata  out  32  packed bytes; byte k on bits [8k+7:8k].
- out_stream_tkeep  out  4  valid byte lanes.
- out_stream_tlast  out  1  last word of a line.
- out_stream_tuser  out  1  first word of a frame.
- out_stream_tvalid  out  1  output word valid.
- out_stream_tready  in  1  downstream accepts word.

Behaviour:
- Clocking and reset: one clock (aclk); reset (areset) is synchronous and active-high.
- Reset values (all outputs, asserted on the areset edge):
  - tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, in_stream_ready=0.
  - phase=0, leftover bytes cleared, flush_pending=0, sof_pending=0.
  - in_stream_ready rises the cycle after areset deasserts.
  - Reset mid-line discards all held bytes and any unsent word.
- Byte stream: each pixel contributes b, g, r in that order, so its lowest byte is b.
- Output register: one-entry output register.
  - Output free = !tvalid || tready.
  - in_stream_ready = output free && !flush_pending && !areset.
  - Pixel accept = valid && in_stream_ready.
  - A word produced by an accept at cycle N has tvalid=1 at N+1.
- Phase counter: 2 bits, advanced on each accept and wrapped 3→0.
  - phase 0: store b,g,r as leftover; no word emitted.
  - phase 1: emit {b1,r0,g0,b0}; keep g1,r1 as leftover.
  - phase 2: emit {g2,b2,r1,g1}; keep r2 as leftover.
  - phase 3: emit {r3,g3,b3,r2}; leftover empty.
- tkeep is 4'b1111 for full words; unused lanes carry 0.
- eol handling: eol forces phase to 0 after the accept.
  - phase 3 + eol: the full word carries tlast=1.
  - phase 0 + eol: emit one word {0,r,g,b}, tkeep=0111, tlast=1.
  - phase 1 + eol: emit the full word with tlast=0; set flush_pending.
    - Next output-free cycle: emit {0,0,r1,g1}, tkeep=0011, tlast=1.
  - phase 2 + eol: same flow; flush word is {0,0,0,r2}, tkeep=0001, tlast=1.
  - in_stream_ready is low while flush_pending.
- sof handling:
  - sof accepted at phase 0: set sof_pending.
  - tuser=1 on the next emitted word (the one containing that pixel's first byte); sof_pending then clears.
  - sof at phase≠0 (misalignment): drop leftover bytes without emitting them; treat the pixel as phase 0; pulse misalign for one cycle.
- tlast, tuser and tdata are held stable while tvalid && !tready.
- sof and eol on the same pixel is legal: a one-pixel line.

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined: adds output ports frame_count[15:0] and misalign_count[15:0].
  - frame_count increments when a word with tuser=1 handshakes.
  - misalign_count increments on each misaligned sof.
  - Both counters saturate at 0xFFFF and reset to 0.
- Undefined: ports absent and no counters; misalign is internal only.

Test Plan:
- Pixels (r,g,b) = (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C), sof on the first, eol on the fourth, tready=1 → tdata 0x06010203, 0x08090405, 0x0A0B0C07. All tkeep=F. tuser=1 on the first word only; tlast=1 on the third only.
- Same pixels with tready low for 3 cycles after the first word → word 0x06010203 held stable; in_stream_ready=0 during the stall; no byte lost or duplicated.
- Two pixels, eol on the second → 0x06010203 (tkeep F, tlast 0), then 0x00000405 (tkeep 0011, tlast 1). in_stream_ready=0 for one cycle.
- One pixel (01,02,03) with sof+eol → single word 0x00010203, tkeep 0111, tlast=1, tuser=1.
- Two pixels, then a third pixel (AA,BB,CC) with sof → leftover dropped, no word for the first two pixels' leftover; misalign pulses; frame_count/misalign_count = 0/1 under PACKER_STATS_EN. The next three pixels complete a word starting 0x..AABBCC.
- Assert areset for 1 cycle after three pixels with tvalid=1 → tvalid=0 the next cycle, phase=0; a fresh 4-pixel group packs correctly.
